tdm_demux_1to4: RTL and testbench

Time-division demultiplexer: receives a single-lane sample stream carrying four interleaved channels, tracks frame alignment via a sync marker, and routes each sample to its own registered channel output. It sits at the receive end of the 4:1 channel-combining path and restores the four lanes the multiplexer merged. It also assembles a coherent four-channel frame snapshot updated once per complete frame.

---
 rtl/tdm_pkg.sv | 6 +
 rtl/tdm_demux_1to4_if.sv | 24 ++
 rtl/demux_1to4_dec.sv | 10 +
 rtl/tdm_demux_1to4.sv | 71 +++++++
 tb/tb_tdm_demux_1to4.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and FSM state type for the TDM demultiplexer
package tdm_pkg;
    localparam int NUM_CH = 4;
    localparam int CH_W = 2;
    typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tdm_demux_1to4_if.sv
// tdm_demux_1to4_if: sample stream in, four channel lanes plus frame snapshot out
interface tdm_demux_1to4_if #(parameter int WIDTH = 8);
    import tdm_pkg::*;
    logic                    in_valid;
    logic                    in_sync;
    logic [WIDTH-1:0]        in_data;
    logic [WIDTH-1:0]        y0;
    logic [WIDTH-1:0]        y1;
    logic [WIDTH-1:0]        y2;
    logic [WIDTH-1:0]        y3;
    logic [NUM_CH-1:0]       y_valid;
    logic [NUM_CH*WIDTH-1:0] frame;
    logic                    frame_done;
    logic                    locked;
    logic                    sync_err;
    modport master (
        output in_valid, in_sync, in_data,
        input  y0, y1, y2, y3, y_valid, frame, frame_done, locked, sync_err
    );
    modport slave (
        input  in_valid, in_sync, in_data,
        output y0, y1, y2, y3, y_valid, frame, frame_done, locked, sync_err
    );
endinterface

// File: rtl/demux_1to4_dec.sv
// demux_1to4_dec: channel select plus enable to one-hot write enable
module demux_1to4_dec
    import tdm_pkg::*;
(
    input  logic [CH_W-1:0]   sel,
    input  logic              en,
    output logic [NUM_CH-1:0] we
);
    assign we = en ? {{(NUM_CH-1){1'b0}}, 1'b1} << sel : '0;
endmodule

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: frame-aligned 1:4 TDM demultiplexer with frame snapshot
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    tdm_demux_1to4_if.slave bus
);
    state_t            state, state_next;
    logic [CH_W-1:0]   ch, ch_next, wsel;
    logic              acc, err;
    logic [NUM_CH-1:0] we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            ch    <= '0;
        end else begin
            state <= state_next;
            ch    <= ch_next;
        end
    end

    // a sync always restarts the frame at ch0, so early sync needs no special path
    always_comb begin
        state_next = state;
        ch_next    = ch;
        wsel       = bus.in_sync ? '0 : ch;
        acc        = 1'b0;
        err        = 1'b0;
        if (bus.in_valid) begin
            if (state == HUNT) begin
                acc        = bus.in_sync;
                state_next = bus.in_sync ? LOCKED : HUNT;
            end else begin
                acc        = bus.in_sync || ch != '0;
                err        = bus.in_sync ? ch != '0 : ch == '0;
                state_next = (!bus.in_sync && ch == '0) ? HUNT : LOCKED;
            end
            ch_next = acc ? wsel + 1'b1 : '0;
        end
    end

    demux_1to4_dec u_dec (.sel(wsel), .en(acc), .we(we));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.y0         <= {WIDTH{1'b0}};
            bus.y1         <= {WIDTH{1'b0}};
            bus.y2         <= {WIDTH{1'b0}};
            bus.y3         <= {WIDTH{1'b0}};
            bus.y_valid    <= '0;
            bus.frame      <= '0;
            bus.frame_done <= 1'b0;
            bus.locked     <= 1'b0;
            bus.sync_err   <= 1'b0;
        end else begin
            if (we[0]) bus.y0 <= bus.in_data;
            if (we[1]) bus.y1 <= bus.in_data;
            if (we[2]) bus.y2 <= bus.in_data;
            if (we[3]) bus.y3 <= bus.in_data;
            if (we[NUM_CH-1]) bus.frame <= {bus.in_data, bus.y2, bus.y1, bus.y0};
            bus.y_valid    <= we;
            bus.frame_done <= we[NUM_CH-1];
            bus.locked     <= state_next == LOCKED;
            bus.sync_err   <= err;
        end
    end
endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb_tdm_demux_1to4: directed stimulus with a queue-based scoreboard and output monitor
module tb_tdm_demux_1to4;
    typedef struct packed {
        logic [3:0]  yv;
        logic [7:0]  yd;
        logic        fd;
        logic [31:0] fr;
        logic        err;
        logic        lk;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ev_t  q[$];
    int   passed = 0;
    int   total = 0;

    tdm_demux_1to4_if #(.WIDTH(8)) bus ();
    tdm_demux_1to4 #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] ysel(input logic [3:0] v);
        return v == 4'b0001 ? bus.y0 : v == 4'b0010 ? bus.y1 :
               v == 4'b0100 ? bus.y2 : v == 4'b1000 ? bus.y3 : 8'h00;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s got=%h exp=%h", n, a, e);
    endtask

    task automatic expect_ev(input logic [3:0] yv, input logic [7:0] yd, input logic fd,
                             input logic [31:0] fr, input logic err, input logic lk);
        ev_t e;
        e = '{yv: yv, yd: yd, fd: fd, fr: fr, err: err, lk: lk};
        q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_y"}, {32'h0, bus.y3, bus.y2, bus.y1, bus.y0}, 64'h0);
        chk({n, "_frame"}, {32'h0, bus.frame}, 64'h0);
        chk({n, "_flags"}, {57'h0, bus.y_valid, bus.frame_done, bus.locked, bus.sync_err}, 64'h0);
    endtask

    initial begin : monitor
        ev_t a, e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.y_valid != 4'b0 || bus.frame_done || bus.sync_err)) begin
                a = '{yv: bus.y_valid, yd: ysel(bus.y_valid), fd: bus.frame_done,
                      fr: bus.frame, err: bus.sync_err, lk: bus.locked};
                total++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_event got=%h", a);
                end else begin
                    e = q.pop_front();
                    if (a === e) passed++;
                    else $display("FAIL event got=%h exp=%h", a, e);
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        drive(1'b1, 1'b0, 8'hAA);
        drive(1'b1, 1'b0, 8'hBB);
        @(negedge clk);
        chk("hunt_locked", {63'h0, bus.locked}, 64'h0);
        chk("hunt_y", {32'h0, bus.y3, bus.y2, bus.y1, bus.y0}, 64'h0);
        @(posedge clk);
        #1;

        expect_ev(4'b0001, 8'h11, 1'b0, 32'h0, 1'b0, 1'b1);
        expect_ev(4'b0010, 8'h22, 1'b0, 32'h0, 1'b0, 1'b1);
        expect_ev(4'b0100, 8'h33, 1'b0, 32'h0, 1'b0, 1'b1);
        expect_ev(4'b1000, 8'h44, 1'b1, 32'h44332211, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'h11);
        drive(1'b1, 1'b0, 8'h22);
        drive(1'b1, 1'b0, 8'h33);
        drive(1'b1, 1'b0, 8'h44);

        expect_ev(4'b0001, 8'h01, 1'b0, 32'h44332211, 1'b0, 1'b1);
        expect_ev(4'b0010, 8'h02, 1'b0, 32'h44332211, 1'b0, 1'b1);
        expect_ev(4'b0001, 8'h10, 1'b0, 32'h44332211, 1'b1, 1'b1);
        expect_ev(4'b0010, 8'h20, 1'b0, 32'h44332211, 1'b0, 1'b1);
        expect_ev(4'b0100, 8'h30, 1'b0, 32'h44332211, 1'b0, 1'b1);
        expect_ev(4'b1000, 8'h40, 1'b1, 32'h40302010, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b0, 8'h02);
        drive(1'b1, 1'b1, 8'h10);
        drive(1'b1, 1'b0, 8'h20);
        drive(1'b1, 1'b0, 8'h30);
        drive(1'b1, 1'b0, 8'h40);

        expect_ev(4'b0000, 8'h00, 1'b0, 32'h40302010, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h55);
        idle(2);

        expect_ev(4'b0001, 8'h11, 1'b0, 32'h40302010, 1'b0, 1'b1);
        expect_ev(4'b0010, 8'h22, 1'b0, 32'h40302010, 1'b0, 1'b1);
        expect_ev(4'b0100, 8'h33, 1'b0, 32'h40302010, 1'b0, 1'b1);
        expect_ev(4'b1000, 8'h44, 1'b1, 32'h44332211, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'h11);
        idle(3);
        drive(1'b1, 1'b0, 8'h22);
        idle(3);
        drive(1'b1, 1'b0, 8'h33);
        idle(3);
        drive(1'b1, 1'b0, 8'h44);
        idle(3);

        expect_ev(4'b0001, 8'h5A, 1'b0, 32'h44332211, 1'b0, 1'b1);
        expect_ev(4'b0010, 8'h5B, 1'b0, 32'h44332211, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'h5A);
        drive(1'b1, 1'b0, 8'h5B);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        expect_ev(4'b0001, 8'hA0, 1'b0, 32'h0, 1'b0, 1'b1);
        expect_ev(4'b0010, 8'hA1, 1'b0, 32'h0, 1'b0, 1'b1);
        expect_ev(4'b0100, 8'hA2, 1'b0, 32'h0, 1'b0, 1'b1);
        expect_ev(4'b1000, 8'hA3, 1'b1, 32'hA3A2A1A0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'hA0);
        drive(1'b1, 1'b0, 8'hA1);
        drive(1'b1, 1'b0, 8'hA2);
        drive(1'b1, 1'b0, 8'hA3);
        idle(4);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
